acc_unloader: RTL

Read-side companion to the polynomial accumulator. On a start pulse it puts the accumulator into output mode (cmd 3), paces `readout` by credit, and captures the even/odd coefficient pairs that come back after the fixed RAM read latency. It reduces each 16-bit coefficient modulo q = 3329 and streams 256 coefficients in index order over a valid/ready port. It sits between the accumulator and the downstream packer/serializer.

---
 rtl/acc_unloader_if.sv | 26 ++
 rtl/acc_unloader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_unloader_if.sv
// Bundles the accumulator read port and the outgoing coefficient stream.
// master = the unloader side, slave = accumulator plus downstream consumer.
interface acc_unloader_if #(
    parameter int AW = 7
);
    logic [3:0]    acc_cmd;
    logic          acc_readout;
    logic [3:0]    acc_status;
    logic [AW-1:0] acc_addr;
    logic [15:0]   acc_data_a;
    logic [15:0]   acc_data_b;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   m_idx;
    logic [11:0]   m_data;

    modport master (
        output acc_cmd, acc_readout, m_valid, m_idx, m_data,
        input  acc_status, acc_addr, acc_data_a, acc_data_b, m_ready
    );

    modport slave (
        input  acc_cmd, acc_readout, m_valid, m_idx, m_data,
        output acc_status, acc_addr, acc_data_a, acc_data_b, m_ready
    );
endinterface

// File: rtl/acc_unloader.sv
// acc_unloader: puts the polynomial accumulator into output mode, pulls its
// coefficient pairs out under a credit scheme, reduces each coefficient
// mod 3329 and streams them in index order, two beats per pair.

// Overflow watchdog for the pair FIFO; the credit rule must keep this quiet.
module acc_unloader_chk (
    input logic clk,
    input logic reset,
    input logic push_i,
    input logic full_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push_i && full_i));
endmodule

module acc_unloader #(
    parameter int NPAIR  = 128,
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           set,
    input  logic           start,
    output logic           busy,
    output logic           done,
    acc_unloader_if.master bus
);
    localparam int AW = $clog2(NPAIR);
    localparam int IW = AW + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam int EW = AW + 24;

    localparam logic [3:0] CMD_IDLE  = 4'd0;
    localparam logic [3:0] CMD_OUT   = 4'd3;
    localparam logic [3:0] STAT_IDLE = 4'd0;
    localparam logic [3:0] STAT_OUT  = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Barrett-style reduction: the quotient estimate is at most one short,
    // so a single conditional subtract makes it exact for any 16-bit input.
    function automatic logic [11:0] red_f(input logic [15:0] x);
        logic [31:0] prod;
        logic [7:0]  t;
        logic [16:0] r;
        prod = 32'(x) * 32'd5039;
        t    = 8'(prod >> 24);
        r    = {1'b0, x} - (17'(t) * 17'd3329);
        if (r >= 17'd3329) begin
            r = r - 17'd3329;
        end else begin
            r = r;
        end
        return 12'(r);
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          acc_cmd_q, acc_cmd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IW-1:0]       issued_q, issued_d;
    logic [IW-1:0]       cap_cnt_q, cap_cnt_d;
    logic                tog_q, tog_d;
    logic [RD_LAT-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [EW-1:0]       mem_d [DEPTH];

    logic                clear_s;
    logic [CW-1:0]       inflight_cnt_s;
    logic                credit_ok_s;
    logic                readout_s;
    logic                push_s;
    logic                valid_s;
    logic                beat_s;
    logic                pop_s;
    logic [EW-1:0]       head_s;

    // Unload sequencing: state transitions, accumulator command and flags.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (bus.acc_status == STAT_OUT) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_STREAM: begin
                if (issued_q == IW'(NPAIR)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) && (fifo_cnt_q == '0) && (cap_cnt_q == IW'(NPAIR))) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RELEASE: begin
                if (bus.acc_status == STAT_IDLE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d == ST_ARM) || (state_d == ST_STREAM) || (state_d == ST_DRAIN)) begin
            acc_cmd_d = CMD_OUT;
        end else begin
            acc_cmd_d = CMD_IDLE;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Credit-paced issue, capture into the pair FIFO and two-beat drain.
    always_comb begin
        inflight_cnt_s = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt_s = inflight_cnt_s + CW'(inflight_q[i]);
        end
        credit_ok_s = (SW'(fifo_cnt_q) + SW'(inflight_cnt_s)) < SW'(DEPTH);
        readout_s   = set && (state_q == ST_STREAM) && (issued_q < IW'(NPAIR)) && credit_ok_s;
        push_s      = inflight_q[RD_LAT-1];
        valid_s     = (fifo_cnt_q != '0);
        beat_s      = valid_s && bus.m_ready;
        pop_s       = beat_s && tog_q;
        head_s      = mem_q[rd_ptr_q];
        inflight_d  = RD_LAT'({inflight_q, readout_s});

        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {bus.acc_addr, red_f(bus.acc_data_a), red_f(bus.acc_data_b)};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + CW'(push_s) - CW'(pop_s);

        if (clear_s) begin
            issued_d  = '0;
            cap_cnt_d = '0;
            tog_d     = 1'b0;
        end else begin
            issued_d  = issued_q + IW'(readout_s);
            cap_cnt_d = cap_cnt_q + IW'(push_s);
            tog_d     = tog_q ^ beat_s;
        end
    end

    // All state registers; a low set freezes everything in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_cmd_q  <= CMD_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            issued_q   <= '0;
            cap_cnt_q  <= '0;
            tog_q      <= 1'b0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
        end else if (set) begin
            state_q    <= state_d;
            acc_cmd_q  <= acc_cmd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            issued_q   <= issued_d;
            cap_cnt_q  <= cap_cnt_d;
            tog_q      <= tog_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign bus.acc_cmd     = acc_cmd_q;
    assign bus.acc_readout = readout_s;
    assign bus.m_valid     = valid_s;
    assign bus.m_idx       = valid_s ? {head_s[EW-1 -: AW], tog_q} : '0;
    assign bus.m_data      = valid_s ? (tog_q ? head_s[11:0] : head_s[23:12]) : 12'd0;

    acc_unloader_chk u_chk (
        .clk    (clk),
        .reset  (reset),
        .push_i (push_s && set),
        .full_i (fifo_cnt_q == CW'(DEPTH))
    );
endmodule
